// File: rtl/bcd_time_pkg.sv
// Shared types and constants for the BCD time-of-day counter.
// The optional alarm is enabled with the BCD_TIME_ALARM_EN macro.
package bcd_time_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t h1;
    bcd_digit_t h0;
    bcd_digit_t m1;
    bcd_digit_t m0;
    bcd_digit_t s1;
    bcd_digit_t s0;
  } time_bcd_t;

  // Digit limits: units, tens of min/sec, 24h hour tens, 24h units at 2x,
  // 12h hour tens, 12h units at 1x.
  localparam bcd_digit_t UNITS_MAX     = 4'd9;
  localparam bcd_digit_t TENS_MAX      = 4'd5;
  localparam bcd_digit_t H1_MAX_24     = 4'd2;
  localparam bcd_digit_t H0_MAX_24     = 4'd3;
  localparam bcd_digit_t H1_MAX_12     = 4'd1;
  localparam bcd_digit_t H0_MAX_12     = 4'd2;

  localparam time_bcd_t TIME_RST_24 = 24'h00_00_00;
  localparam time_bcd_t TIME_RST_12 = 24'h12_00_00;

  // True when every digit is in range for the selected hour mode.
  function automatic logic bcd_time_valid(time_bcd_t t, logic mode24);
    logic ms_ok;
    logic h_ok;
    ms_ok = (t.s0 <= UNITS_MAX) && (t.s1 <= TENS_MAX) &&
            (t.m0 <= UNITS_MAX) && (t.m1 <= TENS_MAX);
    if (mode24) begin
      h_ok = ((t.h1 < H1_MAX_24) && (t.h0 <= UNITS_MAX)) ||
             ((t.h1 == H1_MAX_24) && (t.h0 <= H0_MAX_24));
    end else begin
      h_ok = ((t.h1 == 4'd0) && (t.h0 >= 4'd1) && (t.h0 <= UNITS_MAX)) ||
             ((t.h1 == H1_MAX_12) && (t.h0 <= H0_MAX_12));
    end
    return ms_ok && h_ok;
  endfunction

endpackage

// File: rtl/bcd_time_counter_if.sv
// Load/status bundle of the BCD time-of-day counter.
// Alarm signals exist only when BCD_TIME_ALARM_EN is defined.
interface bcd_time_counter_if;
  import bcd_time_pkg::*;

  logic      en;
  logic      set_vld;
  time_bcd_t set_time;
  logic      set_pm;
  time_bcd_t time_out;
  logic      pm;
  logic      sec_tick;
  logic      day_wrap;
  logic      set_err;
`ifdef BCD_TIME_ALARM_EN
  time_bcd_t alarm_time;
  logic      alarm_pm;
  logic      alarm_arm;
  logic      alarm_hit;

  modport master (
    output en, set_vld, set_time, set_pm, alarm_time, alarm_pm, alarm_arm,
    input  time_out, pm, sec_tick, day_wrap, set_err, alarm_hit
  );
  modport slave (
    input  en, set_vld, set_time, set_pm, alarm_time, alarm_pm, alarm_arm,
    output time_out, pm, sec_tick, day_wrap, set_err, alarm_hit
  );
`else
  modport master (
    output en, set_vld, set_time, set_pm,
    input  time_out, pm, sec_tick, day_wrap, set_err
  );
  modport slave (
    input  en, set_vld, set_time, set_pm,
    output time_out, pm, sec_tick, day_wrap, set_err
  );
`endif
endinterface

// File: rtl/bcd_digit_counter.sv
// Single BCD digit counting 0..MAX with load and carry-out.
module bcd_digit_counter
  import bcd_time_pkg::*;
#(
  parameter int unsigned MAX = 9
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       inc,
  input  logic       ld,
  input  bcd_digit_t ld_val,
  input  bcd_digit_t rst_val,
  output bcd_digit_t count,
  output logic       tc
);

  localparam bcd_digit_t MaxVal = bcd_digit_t'(MAX);

  bcd_digit_t count_q, count_d;

  // Next digit value: load wins over increment, wrap to zero past MAX.
  always_comb begin
    count_d = count_q;
    if (ld) begin
      count_d = ld_val;
    end else if (inc) begin
      count_d = (count_q == MaxVal) ? 4'd0 : count_q + 4'd1;
    end
  end

  // Digit register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) count_q <= rst_val;
    else     count_q <= count_d;
  end

  assign count = count_q;
  assign tc    = inc && (count_q == MaxVal);

endmodule

// File: rtl/bcd_time_counter.sv
// Time-of-day counter: prescaled seconds tick into a BCD s/m/h chain.
// Optional alarm compare is enabled with BCD_TIME_ALARM_EN.
module bcd_time_counter
  import bcd_time_pkg::*;
#(
  parameter int unsigned TICK_DIV = 10,
  parameter int unsigned MODE24   = 1,
  parameter int unsigned DIV_W    = $clog2(TICK_DIV) + 1
) (
  input logic               clk,
  input logic               clr,
  bcd_time_counter_if.slave bus
);

  localparam logic [DIV_W-1:0] DivLast = DIV_W'(TICK_DIV - 1);
  localparam logic             Mode24  = (MODE24 != 0);
  localparam time_bcd_t        TimeRst = Mode24 ? TIME_RST_24 : TIME_RST_12;

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick, ld_ok, ld_bad, adv;
  bcd_digit_t       s0, s1, m0, m1;
  logic             s0_tc, s1_tc, m0_tc, m1_tc;
  bcd_digit_t       h1_q, h1_d, h0_q, h0_d;
  logic             pm_q, pm_d, wrap;
  logic             sec_tick_q, day_wrap_q, set_err_q;

  assign ld_ok  = bus.set_vld && bcd_time_valid(bus.set_time, Mode24);
  assign ld_bad = bus.set_vld && !ld_ok;
  assign tick   = bus.en && (div_q == DivLast);
  // A valid load swallows a coincident tick.
  assign adv    = tick && !ld_ok;

  // Prescaler: cleared by a valid load, frozen while en is low.
  always_comb begin
    div_d = div_q;
    if (ld_ok) begin
      div_d = '0;
    end else if (bus.en) begin
      div_d = (div_q == DivLast) ? '0 : div_q + DIV_W'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (clr) div_q <= '0;
    else     div_q <= div_d;
  end

  bcd_digit_counter #(.MAX(9)) u_s0 (
    .clk(clk), .clr(clr), .inc(adv), .ld(ld_ok), .ld_val(bus.set_time.s0),
    .rst_val(TimeRst.s0), .count(s0), .tc(s0_tc)
  );
  bcd_digit_counter #(.MAX(5)) u_s1 (
    .clk(clk), .clr(clr), .inc(s0_tc), .ld(ld_ok), .ld_val(bus.set_time.s1),
    .rst_val(TimeRst.s1), .count(s1), .tc(s1_tc)
  );
  bcd_digit_counter #(.MAX(9)) u_m0 (
    .clk(clk), .clr(clr), .inc(s1_tc), .ld(ld_ok), .ld_val(bus.set_time.m0),
    .rst_val(TimeRst.m0), .count(m0), .tc(m0_tc)
  );
  bcd_digit_counter #(.MAX(5)) u_m1 (
    .clk(clk), .clr(clr), .inc(m0_tc), .ld(ld_ok), .ld_val(bus.set_time.m1),
    .rst_val(TimeRst.m1), .count(m1), .tc(m1_tc)
  );

  // Hour pair and pm: mode-dependent wrap, day_wrap on midnight.
  always_comb begin
    h1_d = h1_q;
    h0_d = h0_q;
    pm_d = pm_q;
    wrap = 1'b0;
    if (ld_ok) begin
      h1_d = bus.set_time.h1;
      h0_d = bus.set_time.h0;
      pm_d = Mode24 ? 1'b0 : bus.set_pm;
    end else if (m1_tc) begin
      if (Mode24) begin
        if (h1_q == H1_MAX_24 && h0_q == H0_MAX_24) begin
          h1_d = 4'd0;
          h0_d = 4'd0;
          wrap = 1'b1;
        end else if (h0_q == UNITS_MAX) begin
          h1_d = h1_q + 4'd1;
          h0_d = 4'd0;
        end else begin
          h0_d = h0_q + 4'd1;
        end
      end else begin
        if (h1_q == H1_MAX_12 && h0_q == H0_MAX_12) begin
          h1_d = 4'd0;
          h0_d = 4'd1;
        end else if (h1_q == 4'd1 && h0_q == 4'd1) begin
          // 11 -> 12 flips the half-day; PM -> AM is midnight.
          h0_d = 4'd2;
          pm_d = !pm_q;
          wrap = pm_q;
        end else if (h0_q == UNITS_MAX) begin
          h1_d = h1_q + 4'd1;
          h0_d = 4'd0;
        end else begin
          h0_d = h0_q + 4'd1;
        end
      end
    end
  end

  // Hour, pm and pulse registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      h1_q       <= TimeRst.h1;
      h0_q       <= TimeRst.h0;
      pm_q       <= 1'b0;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      h1_q       <= h1_d;
      h0_q       <= h0_d;
      pm_q       <= pm_d;
      sec_tick_q <= adv;
      day_wrap_q <= wrap;
      set_err_q  <= ld_bad;
    end
  end

  assign bus.time_out = {h1_q, h0_q, m1, m0, s1, s0};
  assign bus.pm       = pm_q;
  assign bus.sec_tick = sec_tick_q;
  assign bus.day_wrap = day_wrap_q;
  assign bus.set_err  = set_err_q;

`ifdef BCD_TIME_ALARM_EN
  // Qualified by sec_tick so a load onto the alarm time never fires.
  assign bus.alarm_hit = sec_tick_q && bus.alarm_arm &&
                         (bus.time_out == bus.alarm_time) &&
                         (Mode24 || (pm_q == bus.alarm_pm));
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: three instances (24h/div10, 12h/div10,
// 24h/div1) share one stimulus stream and are checked every cycle against
// a seconds-since-midnight model.
module tb_bcd_time_counter;

  localparam int TD  [3] = '{10, 10, 1};
  localparam bit M24 [3] = '{1'b1, 1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        clr, en, set_vld, set_pm;
  logic [23:0] set_time;
  logic [23:0] alarm_time;
  logic        alarm_pm, alarm_arm;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tick_cnt0, wrap_cnt0;

  int msecs [3];
  int mpre  [3];
  bit etick [3];
  bit ewrap [3];
  bit eerr  [3];
  bit ehit  [3];

  logic [27:0] obs [3];
  logic        hit_obs [3];

  always #5 clk = ~clk;

  bcd_time_counter_if if0 ();
  bcd_time_counter_if if1 ();
  bcd_time_counter_if if2 ();

  assign if0.en = en;  assign if0.set_vld = set_vld;
  assign if0.set_time = set_time;  assign if0.set_pm = set_pm;
  assign if1.en = en;  assign if1.set_vld = set_vld;
  assign if1.set_time = set_time;  assign if1.set_pm = set_pm;
  assign if2.en = en;  assign if2.set_vld = set_vld;
  assign if2.set_time = set_time;  assign if2.set_pm = set_pm;

  assign obs[0] = {if0.time_out, if0.pm, if0.sec_tick, if0.day_wrap, if0.set_err};
  assign obs[1] = {if1.time_out, if1.pm, if1.sec_tick, if1.day_wrap, if1.set_err};
  assign obs[2] = {if2.time_out, if2.pm, if2.sec_tick, if2.day_wrap, if2.set_err};

`ifdef BCD_TIME_ALARM_EN
  assign if0.alarm_time = alarm_time; assign if0.alarm_pm = alarm_pm;
  assign if0.alarm_arm = alarm_arm;
  assign if1.alarm_time = alarm_time; assign if1.alarm_pm = alarm_pm;
  assign if1.alarm_arm = alarm_arm;
  assign if2.alarm_time = alarm_time; assign if2.alarm_pm = alarm_pm;
  assign if2.alarm_arm = alarm_arm;
  assign hit_obs[0] = if0.alarm_hit;
  assign hit_obs[1] = if1.alarm_hit;
  assign hit_obs[2] = if2.alarm_hit;
`else
  assign hit_obs[0] = 1'b0;
  assign hit_obs[1] = 1'b0;
  assign hit_obs[2] = 1'b0;
`endif

  bcd_time_counter #(.TICK_DIV(10), .MODE24(1)) u_dut0 (.clk(clk), .clr(clr), .bus(if0));
  bcd_time_counter #(.TICK_DIV(10), .MODE24(0)) u_dut1 (.clk(clk), .clr(clr), .bus(if1));
  bcd_time_counter #(.TICK_DIV(1),  .MODE24(1)) u_dut2 (.clk(clk), .clr(clr), .bus(if2));

  // {pm, hh, mm, ss} as displayed for seconds-since-midnight s.
  function automatic logic [24:0] disp(int s, bit m24);
    int h, m, sec, hd;
    logic p;
    h = s / 3600;
    m = (s / 60) % 60;
    sec = s % 60;
    if (m24) begin
      hd = h;
      p  = 1'b0;
    end else begin
      p  = (h >= 12);
      hd = (h % 12 == 0) ? 12 : h % 12;
    end
    return {p, 4'(hd / 10), 4'(hd % 10), 4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
  endfunction

  // Seconds-since-midnight for a load request, or -1 if it is rejected.
  function automatic int parse(logic [23:0] t, logic p, bit m24);
    int d [6];
    int h, m, s;
    for (int i = 0; i < 6; i++) d[i] = int'(t[23 - 4 * i -: 4]);
    for (int i = 0; i < 6; i++) if (d[i] > 9) return -1;
    h = d[0] * 10 + d[1];
    m = d[2] * 10 + d[3];
    s = d[4] * 10 + d[5];
    if (m > 59 || s > 59) return -1;
    if (m24) begin
      if (h > 23) return -1;
    end else begin
      if (h < 1 || h > 12) return -1;
      h = (h % 12) + (p ? 12 : 0);
    end
    return h * 3600 + m * 60 + s;
  endfunction

  function automatic logic [27:0] expv(int k);
    logic [24:0] d;
    d = disp(msecs[k], M24[k]);
    return {d[23:0], d[24], etick[k], ewrap[k], eerr[k]};
  endfunction

  task automatic check(string tag, logic [31:0] o, logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_step();
    int ld;
    bit tk;
    logic [24:0] d;
    for (int k = 0; k < 3; k++) begin
      if (clr) begin
        msecs[k] = 0; mpre[k] = 0;
        etick[k] = 0; ewrap[k] = 0; eerr[k] = 0; ehit[k] = 0;
      end else begin
        ld = set_vld ? parse(set_time, set_pm, M24[k]) : -1;
        eerr[k] = set_vld && (ld < 0);
        tk = en && (mpre[k] == TD[k] - 1);
        if (ld >= 0) begin
          msecs[k] = ld; mpre[k] = 0; etick[k] = 0; ewrap[k] = 0;
        end else begin
          if (en) mpre[k] = (mpre[k] + 1) % TD[k];
          if (tk) msecs[k] = (msecs[k] + 1) % 86400;
          etick[k] = tk;
          ewrap[k] = tk && (msecs[k] == 0);
        end
        d = disp(msecs[k], M24[k]);
        ehit[k] = etick[k] && alarm_arm && (d[23:0] == alarm_time) &&
                  (M24[k] || (d[24] == alarm_pm));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("dut%0d_cyc%0d", k, cyc), {4'h0, obs[k]}, {4'h0, expv(k)});
`ifdef BCD_TIME_ALARM_EN
      check($sformatf("dut%0d_alarm_cyc%0d", k, cyc), {31'd0, hit_obs[k]}, {31'd0, ehit[k]});
`endif
    end
    if (obs[0][2]) tick_cnt0++;
    if (obs[0][1]) wrap_cnt0++;
  endtask

  task automatic load(logic [23:0] t, logic p);
    set_vld = 1'b1; set_time = t; set_pm = p;
    step();
    set_vld = 1'b0;
  endtask

  initial begin
    logic [24:0] frozen;
    clr = 1'b1; en = 1'b0; set_vld = 1'b0; set_pm = 1'b0; set_time = '0;
    alarm_time = '0; alarm_pm = 1'b0; alarm_arm = 1'b0;
    step(); step();
    check("reset24", {8'd0, if0.time_out}, 32'h00_000000);
    check("reset12", {7'd0, if1.time_out, if1.pm}, {7'd0, 24'h120000, 1'b0});
    clr = 1'b0;

    // 600 cycles at div 10 -> one minute
    en = 1'b1; tick_cnt0 = 0;
    repeat (600) step();
    check("run600_time", {8'd0, if0.time_out}, 32'h00_000100);
    check("run600_ticks", tick_cnt0, 60);

    // 24h midnight rollover
    load(24'h235958, 1'b0);
    wrap_cnt0 = 0;
    repeat (20) step();
    check("wrap24_time", {8'd0, if0.time_out}, 32'h0);
    check("wrap24_cnt", wrap_cnt0, 1);

    // 12h half-day transitions
    load(24'h115959, 1'b0);
    repeat (10) step();
    check("am_to_pm", {6'd0, if1.time_out, if1.pm, if1.day_wrap}, {6'd0, 24'h120000, 2'b10});
    load(24'h115959, 1'b1);
    repeat (10) step();
    check("pm_to_am", {6'd0, if1.time_out, if1.pm, if1.day_wrap}, {6'd0, 24'h120000, 2'b01});
    load(24'h125959, 1'b0);
    repeat (10) step();
    check("twelve_to_one", {8'd0, if1.time_out}, {8'd0, 24'h010000});

    // Rejected loads leave the time alone
    frozen = disp(msecs[0], 1'b1);
    load(24'h126000, 1'b0);
    check("bad_min", {7'd0, if0.time_out, if0.set_err}, {7'd0, frozen[23:0], 1'b1});
    load(24'h240000, 1'b0);
    check("bad_hour", {7'd0, if0.time_out, if0.set_err}, {7'd0, frozen[23:0], 1'b1});
    load(24'h00000A, 1'b0);
    check("bad_nonbcd", {7'd0, if0.time_out, if0.set_err}, {7'd0, frozen[23:0], 1'b1});

    // Load coincident with a tick of the div-10 instances
    for (int i = 0; i < 20 && mpre[0] != TD[0] - 1; i++) step();
    check("align_tick", mpre[0], TD[0] - 1);
    load(24'h053000, 1'b0);
    check("coinc_load", {7'd0, if0.time_out, if0.sec_tick}, {7'd0, 24'h053000, 1'b0});
    repeat (9) step();
    check("coinc_wait", {7'd0, if0.time_out, if0.sec_tick}, {7'd0, 24'h053000, 1'b0});
    step();
    check("coinc_next", {7'd0, if0.time_out, if0.sec_tick}, {7'd0, 24'h053001, 1'b1});

    // Clear mid-run
    repeat (3) step();
    clr = 1'b1;
    step();
    check("clr_mid", {8'd0, if0.time_out}, 32'h0);
    clr = 1'b0;

    // Freeze with en low
    repeat (7) step();
    frozen = disp(msecs[2], 1'b1);
    en = 1'b0;
    repeat (5) step();
    check("freeze", {8'd0, if2.time_out}, {8'd0, frozen[23:0]});
    en = 1'b1;

    // Random stimulus
    for (int i = 0; i < 800; i++) begin
      logic [24:0] r;
      en      = ($urandom_range(3) != 0);
      clr     = ($urandom_range(199) == 0);
      set_vld = ($urandom_range(15) == 0);
      set_pm  = 1'($urandom_range(1));
      case ($urandom_range(2))
        0: begin
          r = disp(int'($urandom_range(86399)), 1'b1);
          set_time = r[23:0];
        end
        1: begin
          r = disp(int'($urandom_range(86399, 86390)), $urandom_range(1) == 1);
          set_time = r[23:0];
          set_pm   = r[24];
        end
        default: set_time = 24'($urandom);
      endcase
      step();
    end
    clr = 1'b0; set_vld = 1'b0; en = 1'b1;

`ifdef BCD_TIME_ALARM_EN
    alarm_time = 24'h000003; alarm_pm = 1'b0; alarm_arm = 1'b1;
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (3) step();
    check("alarm_third_tick", {30'd0, if2.alarm_hit, if2.sec_tick}, 32'd3);
    repeat (30) step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
